pipe_buffer_reg: RTL and testbench
==================================

Name: pipe_buffer_reg

Overview:
Parametrised, elastic successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB buffer structs. It carries one packed stage payload of WIDTH bits between two pipeline stages. It uses a valid/ready handshake, a 2-entry skid buffer so stalls need no combinational ready path, and synchronous flush that inserts a parametrised bubble. One instance replaces each hand-written stage register in the 5-stage core.

Parameters:
WIDTH, 32, payload width in bits (>=1); set to $bits of the stage struct.
BUBBLE, '0, payload value presented when out_valid=0 (e.g. NOP-encoded CurrInstr field).

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous reset, active-high.
flush  input  1  synchronous flush; discards all held and incoming entries.
in_valid  input  1  upstream stage offers in_data.
in_ready  output  1  buffer can accept this cycle.
in_data  input  WIDTH  upstream payload.
out_valid  output  1  out_data holds a real entry.
out_ready  input  1  downstream consumes this cycle.
out_data  output  WIDTH  head payload; BUBBLE when out_valid=0.

Behaviour:
- Handshake rules:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Payload is transferred only on fire.
  - in_valid may be asserted without waiting for in_ready.
  - out_data and out_valid stay stable while out_valid=1 and out_ready=0.
- Storage: main register (drives out_data) plus skid register. State is EMPTY (0 entries), ONE, or FULL (2 entries). out_valid = (state != EMPTY).
- in_ready = (state != FULL) & ~flush & ~reset. It is a pure function of registered state plus the flush and reset inputs; it never depends on out_ready.
- Transitions when flush=0:
  - EMPTY, in_fire: main<=in_data; go to ONE.
  - ONE, in_fire & out_fire: main<=in_data; stay in ONE.
  - ONE, in_fire & ~out_fire: skid<=in_data; go to FULL.
  - ONE, out_fire & ~in_fire: main<=BUBBLE; go to EMPTY.
  - FULL, out_fire: main<=skid; skid<=BUBBLE; go to ONE.
  - No fire: hold.
- Latency: an entry accepted at edge N appears on out_data after edge N (1 cycle) when the buffer was EMPTY, or when it was ONE and the head drained that same cycle. Otherwise it waits behind earlier entries.
- Ordering is strict FIFO. No entry is duplicated or dropped except by flush.
- Flush (highest priority after reset):
  - On the flush edge, state<=EMPTY and main<=BUBBLE; skid<=BUBBLE.
  - in_ready=0 during flush, so no entry is accepted that cycle.
  - An out_fire coincident with flush still counts as consumed downstream.
- Reset (asynchronous):
  - State EMPTY, main=skid=BUBBLE, out_valid=0, out_data=BUBBLE, in_ready=0 while reset=1.
  - in_ready=1 on the first cycle after deassertion.
  - Reset mid-transfer discards everything.
- Full boundary: in FULL, in_valid is ignored. in_ready rises the cycle after the out_fire that returns the buffer to ONE.

Optional Feature:
PIPE_BUFFER_PERF_EN.
- Defined: adds outputs stall_cycles[31:0] and bubble_cycles[31:0].
  - stall_cycles increments each cycle out_valid & ~out_ready.
  - bubble_cycles increments each cycle ~out_valid.
  - Both counters saturate at 32'hFFFF_FFFF, reset to 0 on reset, and are cleared by flush.
- Undefined: both ports and all counter logic are absent; the remaining behaviour is identical.

Test Plan:
1. Reset, then out_ready=1 and in_valid=1 with payloads 0x11, 0x22, 0x33 on consecutive cycles -> out_data 0x11, 0x22, 0x33 one cycle later each, out_valid continuous, in_ready always 1.
2. out_ready=0 while feeding 0xA1, 0xA2, 0xA3 -> in_ready drops after 0xA2 is accepted and 0xA3 is held off. Raise out_ready -> outputs in order 0xA1, 0xA2, 0xA3 with nothing lost.
3. FULL state with 0xB1/0xB2, then assert flush one cycle with in_valid=1 and data 0xB3 -> next cycle out_valid=0, out_data=BUBBLE, 0xB3 never appears.
4. BUBBLE=32'h00000013, WIDTH=32 -> after reset and after flush, out_data=0x00000013 with out_valid=0.
5. Assert reset asynchronously mid-cycle while in state ONE holding 0xC1 -> out_valid and in_ready fall immediately without a clock edge, out_data=BUBBLE; 0xC1 never emitted after release.
6. With PIPE_BUFFER_PERF_EN: hold 1 entry with out_ready=0 for 5 cycles, then leave EMPTY for 3 cycles -> stall_cycles=5, bubble_cycles=3 (counted since reset deassertion excluding pre-load cycles); flush -> both read 0.

Source files
------------

// File: rtl/pipe_buffer_reg.sv
// Elastic two-entry pipeline stage register with valid/ready handshake, skid slot and flush-to-bubble.
// Optional idle/stall counters are built when PIPE_BUFFER_PERF_EN is defined.
module pipe_buffer_reg #(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_BUFFER_PERF_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      bubble_cycles
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] main_r;
    logic [WIDTH-1:0] main_nxt_s;
    logic [WIDTH-1:0] skid_r;
    logic [WIDTH-1:0] skid_nxt_s;
    logic             out_valid_r;
    logic             in_fire_s;
    logic             out_fire_s;

    // in_ready looks only at held state, flush and reset so stalls never chain combinationally
    assign in_ready   = (state_r != FULL) & ~flush & ~reset;
    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid_r & out_ready;
    assign out_valid  = out_valid_r;
    assign out_data   = main_r;

    // Next-state and payload steering; flush overrides every handshake
    always_comb begin
        state_nxt_s = state_r;
        main_nxt_s  = main_r;
        skid_nxt_s  = skid_r;
        if (flush) begin
            state_nxt_s = EMPTY;
            main_nxt_s  = BUBBLE;
            skid_nxt_s  = BUBBLE;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_fire_s) begin
                        main_nxt_s  = in_data;
                        state_nxt_s = ONE;
                    end else begin
                        state_nxt_s = EMPTY;
                    end
                end
                ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        main_nxt_s = in_data;
                    end else if (in_fire_s) begin
                        skid_nxt_s  = in_data;
                        state_nxt_s = FULL;
                    end else if (out_fire_s) begin
                        main_nxt_s  = BUBBLE;
                        state_nxt_s = EMPTY;
                    end else begin
                        state_nxt_s = ONE;
                    end
                end
                FULL: begin
                    if (out_fire_s) begin
                        main_nxt_s  = skid_r;
                        skid_nxt_s  = BUBBLE;
                        state_nxt_s = ONE;
                    end else begin
                        state_nxt_s = FULL;
                    end
                end
                default: begin
                    state_nxt_s = EMPTY;
                    main_nxt_s  = BUBBLE;
                    skid_nxt_s  = BUBBLE;
                end
            endcase
        end
    end

    // State and payload registers; out_valid is kept as its own flop to stay glitch-free
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= EMPTY;
            main_r      <= BUBBLE;
            skid_r      <= BUBBLE;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            main_r      <= main_nxt_s;
            skid_r      <= skid_nxt_s;
            out_valid_r <= (state_nxt_s != EMPTY);
        end
    end

`ifdef PIPE_BUFFER_PERF_EN
    logic [31:0] stall_r;
    logic [31:0] bubble_r;

    assign stall_cycles  = stall_r;
    assign bubble_cycles = bubble_r;

    // Saturating back-pressure and empty-slot counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_r  <= 32'd0;
            bubble_r <= 32'd0;
        end else if (flush) begin
            stall_r  <= 32'd0;
            bubble_r <= 32'd0;
        end else begin
            if (out_valid_r && !out_ready && (stall_r != 32'hFFFF_FFFF)) begin
                stall_r <= stall_r + 32'd1;
            end
            if (!out_valid_r && (bubble_r != 32'hFFFF_FFFF)) begin
                bubble_r <= bubble_r + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_buffer_reg.sv
// Scoreboard bench for pipe_buffer_reg: driver pushes accepted payloads into a FIFO model,
// an independent monitor pops and compares whenever the buffer presents an entry.
module tb_pipe_buffer_reg;

    localparam int          W   = 32;
    localparam logic [31:0] BUB = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = 32'd0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
`ifdef PIPE_BUFFER_PERF_EN
    logic [31:0]   stall_cycles;
    logic [31:0]   bubble_cycles;
    int unsigned   stall_m  = 0;
    int unsigned   bubble_m = 0;
`endif

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   exp_q[$];

    always #5 clk = ~clk;

    pipe_buffer_reg #(.WIDTH(W), .BUBBLE(BUB)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_BUFFER_PERF_EN
        , .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Offer one cycle of stimulus; the model learns of an acceptance only after the edge
    task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f);
        logic fire;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        fire = v && !f && (exp_q.size() < 2);
        @(posedge clk);
        if (f) exp_q.delete();
        else if (fire) exp_q.push_back(d);
        @(negedge clk);
    endtask

    // Asynchronous reset raised between edges, held across one edge
    task automatic async_reset();
        #2;
        in_valid = 1'b0;
        flush    = 1'b0;
        reset    = 1'b1;
        #1;
        chk("async_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_in_ready", {31'd0, in_ready}, 32'd0);
        chk("async_out_data", out_data, BUB);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: compare against the FIFO model just before each active edge
    always begin
        logic        ev;
        logic        er;
        logic [31:0] ed;
        @(negedge clk);
        #4;
        ev = (exp_q.size() != 0) && !reset;
        ed = ev ? exp_q[0] : BUB;
        er = (exp_q.size() < 2) && !flush && !reset;
        chk("in_ready", {31'd0, in_ready}, {31'd0, er});
        chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
        chk("out_data", out_data, ed);
        if (ev && out_ready) void'(exp_q.pop_front());
`ifdef PIPE_BUFFER_PERF_EN
        if (reset) begin
            stall_m  = 0;
            bubble_m = 0;
        end
        chk("stall_cycles", stall_cycles, stall_m);
        chk("bubble_cycles", bubble_cycles, bubble_m);
        if (!reset) begin
            if (flush) begin
                stall_m  = 0;
                bubble_m = 0;
            end else begin
                if (ev && !out_ready) stall_m++;
                if (!ev) bubble_m++;
            end
        end
`endif
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        // streaming with downstream always ready
        step(1'b1, 32'h11, 1'b1, 1'b0);
        step(1'b1, 32'h22, 1'b1, 1'b0);
        step(1'b1, 32'h33, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        // back-pressure fills both slots, third offer waits
        step(1'b1, 32'hA1, 1'b0, 1'b0);
        step(1'b1, 32'hA2, 1'b0, 1'b0);
        step(1'b1, 32'hA3, 1'b0, 1'b0);
        step(1'b1, 32'hA3, 1'b0, 1'b0);
        step(1'b1, 32'hA3, 1'b1, 1'b0);
        step(1'b1, 32'hA3, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        // flush from FULL with a competing offer
        step(1'b1, 32'hB1, 1'b0, 1'b0);
        step(1'b1, 32'hB2, 1'b0, 1'b0);
        step(1'b1, 32'hB3, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        // asynchronous reset while holding one entry
        step(1'b1, 32'hC1, 1'b0, 1'b0);
        async_reset();
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        // one entry stalled five cycles, then three empty cycles, then flush
        step(1'b1, 32'hD1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        // randomized traffic with occasional flush
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 29) == 0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
